// File: rtl/moore_pattern_detector_pkg.sv
// moore_pkg: shared constants for the Moore serial pattern detector.
//   clog2_p1()        - state register width for a given pattern length
//   DEF_PAT_LEN/...   - default pattern configuration (0110, 4 bits)
//   MODE_OVERLAP/...  - values for the OVERLAP parameter
package moore_pkg;

    localparam int MODE_OVERLAP = 1;
    localparam int MODE_RESTART = 0;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b0110;
    localparam int         DEF_CNT_W   = 8;

    // State holds 0..n inclusive, so it needs room for n+1 values.
    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/moore_pattern_detector_prefix_match.sv
// prefix_match: combinational next-state search for the pattern detector.
//   h_next_i     - history including the bit being accepted (newest at bit 0)
//   s_eff_i      - effective current state (prefix length matched so far)
//   next_state_o - longest k <= min(s_eff_i+1, PAT_LEN) whose last k history
//                  bits equal the first k pattern bits
module prefix_match
    import moore_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 ST_W    = clog2_p1(PAT_LEN)
) (
    input  logic [PAT_LEN-1:0] h_next_i,
    input  logic [ST_W-1:0]    s_eff_i,
    output logic [ST_W-1:0]    next_state_o
);

    // hit[k]: newest k history bits equal the first k pattern bits
    logic [PAT_LEN:1] hit;

    for (genvar k = 1; k <= PAT_LEN; k++) begin : g_hit
        assign hit[k] = (h_next_i[k-1:0] == PATTERN[PAT_LEN-1 -: k]);
    end

    // The S_eff+1 bound keeps history older than the current partial match
    // (or left over from before a restart) from producing a false prefix.
    always_comb begin
        logic found;
        found        = 1'b0;
        next_state_o = '0;
        for (int k = PAT_LEN; k >= 1; k--) begin
            if (!found && hit[k] && (k <= int'(s_eff_i) + 1)) begin
                next_state_o = ST_W'(k);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/moore_pattern_detector.sv
// moore_pattern_detector: parametrised Moore serial pattern detector.
//   clock       - rising-edge clock
//   reset       - asynchronous active-low reset
//   clear       - synchronous clear, overrides x_en
//   x_en        - x_in is valid this cycle
//   x_in        - serial data bit (first bit compared with PATTERN[PAT_LEN-1])
//   y_out       - prefix length currently matched (0..PAT_LEN)
//   detect      - high while the full pattern is matched
//   match_count - saturating count of transitions into the full-match state
module moore_pattern_detector
    import moore_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 OVERLAP = MODE_OVERLAP,
    parameter int                 CNT_W   = DEF_CNT_W,
    localparam int                ST_W    = clog2_p1(PAT_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             x_en,
    input  logic             x_in,
    output logic [ST_W-1:0]  y_out,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ST_W-1:0]    state_q, state_d, s_eff;
    // The oldest history bit is shifted straight out and never compared,
    // so only the lower PAT_LEN-1 bits need storage.
    logic [PAT_LEN-2:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               detect_q;

    assign hist_d = {hist_q, x_in};

    // In restart mode a completed match forgets everything it consumed.
    assign s_eff = (OVERLAP == MODE_RESTART && state_q == FULL) ? '0 : state_q;

    prefix_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .ST_W    (ST_W)
    ) u_match (
        .h_next_i     (hist_d),
        .s_eff_i      (s_eff),
        .next_state_o (state_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= '0;
            hist_q   <= '0;
            cnt_q    <= '0;
            detect_q <= 1'b0;
        end else if (clear) begin
            state_q  <= '0;
            hist_q   <= '0;
            cnt_q    <= '0;
            detect_q <= 1'b0;
        end else if (x_en) begin
            state_q  <= state_d;
            hist_q   <= hist_d[PAT_LEN-2:0];
            detect_q <= (state_d == FULL);
            // Counts every accepted bit landing in FULL, including FULL->FULL.
            if (state_d == FULL && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign y_out       = state_q;
    assign detect      = detect_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_moore_pattern_detector.sv
module tb_moore_pattern_detector;

    localparam int N = 5;

    // Per-DUT configuration as seen by the reference model.
    int ML  [N] = '{4, 4, 4, 4, 5};
    int MP  [N] = '{6, 6, 15, 15, 22};   // 0110, 0110, 1111, 1111, 10110
    int MOV [N] = '{1, 0, 1, 1, 1};
    int MCW [N] = '{8, 8, 8, 2, 8};

    logic clock, reset, clear, x_en, x_in;
    logic [2:0] y_o   [N];
    logic       det_o [N];
    logic [7:0] cnt_o [N];
    logic [1:0] cnt3;
    assign cnt_o[3] = {6'd0, cnt3};

    moore_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b0110), .OVERLAP(1), .CNT_W(8)) u_d0 (
        .clock(clock), .reset(reset), .clear(clear), .x_en(x_en), .x_in(x_in),
        .y_out(y_o[0]), .detect(det_o[0]), .match_count(cnt_o[0]));
    moore_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b0110), .OVERLAP(0), .CNT_W(8)) u_d1 (
        .clock(clock), .reset(reset), .clear(clear), .x_en(x_en), .x_in(x_in),
        .y_out(y_o[1]), .detect(det_o[1]), .match_count(cnt_o[1]));
    moore_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(8)) u_d2 (
        .clock(clock), .reset(reset), .clear(clear), .x_en(x_en), .x_in(x_in),
        .y_out(y_o[2]), .detect(det_o[2]), .match_count(cnt_o[2]));
    moore_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) u_d3 (
        .clock(clock), .reset(reset), .clear(clear), .x_en(x_en), .x_in(x_in),
        .y_out(y_o[3]), .detect(det_o[3]), .match_count(cnt3));
    moore_pattern_detector #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1), .CNT_W(8)) u_d4 (
        .clock(clock), .reset(reset), .clear(clear), .x_en(x_en), .x_in(x_in),
        .y_out(y_o[4]), .detect(det_o[4]), .match_count(cnt_o[4]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: the state is the longest suffix of the bits accepted
    // since the last (re)start that equals a prefix of the pattern.
    int m_st [N], m_wl [N], m_wb [N], m_cnt [N];

    function automatic int longest(input int L, input int P, input int wb, input int wl);
        for (int k = L; k >= 1; k--)
            if (k <= wl && ((wb & ((1 << k) - 1)) == (P >> (L - k))))
                return k;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_wl[i] = 0; m_wb[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input bit c, input bit e, input bit x);
        for (int i = 0; i < N; i++) begin
            if (c) begin
                m_st[i] = 0; m_wl[i] = 0; m_wb[i] = 0; m_cnt[i] = 0;
            end else if (e) begin
                if (m_st[i] == ML[i] && MOV[i] == 0) begin
                    m_wl[i] = 0; m_wb[i] = 0;
                end
                m_wb[i] = ((m_wb[i] << 1) | int'(x)) & 'hFFFF;
                m_wl[i] = (m_wl[i] + 1 > ML[i]) ? ML[i] : m_wl[i] + 1;
                m_st[i] = longest(ML[i], MP[i], m_wb[i], m_wl[i]);
                if (m_st[i] == ML[i] && m_cnt[i] < (1 << MCW[i]) - 1)
                    m_cnt[i]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_y%0d", tag, i), int'(y_o[i]), m_st[i]);
            chk($sformatf("%s_det%0d", tag, i), int'(det_o[i]), int'(m_st[i] == ML[i]));
            chk($sformatf("%s_cnt%0d", tag, i), int'(cnt_o[i]), m_cnt[i]);
        end
    endtask

    task automatic step(input bit c, input bit e, input bit x);
        clear = c; x_en = e; x_in = x;
        @(posedge clock);
        model_step(c, e, x);
        #1;
        check_all("step");
    endtask

    // Pulse reset low between edges; outputs must clear without a clock.
    task automatic arst_pulse();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #1 reset = 1'b1;
    endtask

    initial begin
        int s7 [7]   = '{0, 1, 1, 0, 1, 1, 0};
        int eo [7]   = '{1, 2, 3, 4, 2, 3, 4};
        int er [7]   = '{1, 2, 3, 4, 0, 0, 1};
        int e11 [6]  = '{1, 2, 3, 4, 4, 4};
        int ge [7]   = '{1, 0, 1, 0, 0, 1, 1};
        int gx [7]   = '{0, 0, 1, 0, 0, 1, 0};
        int ey [7]   = '{1, 1, 2, 2, 2, 3, 4};
        int b3 [3]   = '{1, 1, 0};
        int e3 [3]   = '{0, 0, 1};

        reset = 1'b0; clear = 1'b0; x_en = 1'b0; x_in = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // 0110110: overlap vs restart
        for (int j = 0; j < 7; j++) begin
            step(0, 1, s7[j][0]);
            chk("ov_y", int'(y_o[0]), eo[j]);
            chk("rs_y", int'(y_o[1]), er[j]);
        end
        chk("ov_cnt", int'(cnt_o[0]), 2);
        chk("rs_cnt", int'(cnt_o[1]), 1);

        // 1111 self-overlap
        step(1, 0, 0);
        for (int j = 0; j < 6; j++) begin
            step(0, 1, 1);
            chk("ones_y", int'(y_o[2]), e11[j]);
        end
        chk("ones_cnt", int'(cnt_o[2]), 3);

        // gaps with x_en low
        step(1, 0, 0);
        for (int j = 0; j < 7; j++) begin
            step(0, ge[j][0], gx[j][0]);
            chk("gap_y", int'(y_o[0]), ey[j]);
        end
        repeat (3) step(0, 0, 1);
        chk("gap_det", int'(det_o[0]), 1);
        chk("gap_cnt", int'(cnt_o[0]), 1);

        // async reset mid-pattern
        step(1, 0, 0);
        step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
        arst_pulse();
        chk("arst_y0", int'(y_o[0]), 0);
        for (int j = 0; j < 3; j++) begin
            step(0, 1, b3[j][0]);
            chk("post_arst_y", int'(y_o[0]), e3[j]);
            chk("post_arst_det", int'(det_o[0]), 0);
        end

        // saturation at CNT_W=2, then clear beats x_en
        step(1, 0, 0);
        repeat (8) step(0, 1, 1);
        chk("sat_cnt", int'(cnt_o[3]), 3);
        step(1, 1, 1);
        chk("clr_y", int'(y_o[3]), 0);
        chk("clr_cnt", int'(cnt_o[3]), 0);

        // randomized stream
        for (int j = 0; j < 1500; j++) begin
            step(($urandom % 60) == 0, ($urandom % 4) != 0, $urandom % 2);
            if ((j % 211) == 210) arst_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/moore_pattern_detector.md
Name: moore_pattern_detector

Overview:
- Parametrised Moore serial pattern detector; successor to the fixed 4-state zero-detector FSMs in Sequential_Circuits/Moore_machine.
- Pattern, its length and overlap mode are elaboration-time parameters.
- State encodes the length of the longest pattern prefix just matched; the accept state drives a Moore detect output.
- A saturating match counter is included.
- Sits on a 1-bit serial input stream with a per-cycle enable and a synchronous clear.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b0110, pattern bits; the first bit received is compared with PATTERN[PAT_LEN-1].
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = restart from empty after each match.
- CNT_W, 8, match counter width.
- Derived: ST_W = $clog2(PAT_LEN+1).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear; priority over x_en.
- x_en, input, 1, qualifies x_in this cycle.
- x_in, input, 1, serial data bit.
- y_out, output, ST_W, current state (number of prefix bits matched, 0..PAT_LEN).
- detect, output, 1, high while state == PAT_LEN.
- match_count, output, CNT_W, number of detections; saturates at all-ones.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, named clock and reset.
- Reset (reset==0): state=0, history=0, match_count=0, so y_out=0 and detect=0 immediately, without waiting for a clock edge.
- clear=1 at a clock edge: same values as reset. x_en is ignored that cycle.
- x_en=0, clear=0: state, history and count hold.
- history is a PAT_LEN-bit shift register. On each accepted bit, h_next = {h[PAT_LEN-2:0], x_in}.
- Effective state S_eff:
  - S_eff = state, except when OVERLAP=0 and state==PAT_LEN, where S_eff = 0.
- Next state on an accepted bit:
  - Largest k in 0..min(S_eff+1, PAT_LEN) such that h_next[k-1:0] == PATTERN[PAT_LEN-1 -: k].
  - k=0 always qualifies.
  - This is equivalent to KMP failure transitions. The bound by S_eff+1 keeps stale history from creating false matches.
- Implement the next-state logic combinationally as a priority search from k=PAT_LEN downward. No precomputed tables are required.
- Moore outputs:
  - y_out = state.
  - detect = (state == PAT_LEN).
  - Detect rises one clock after the edge that samples the final pattern bit and lasts exactly one accepted-bit period, or longer if x_en stays low.
- match_count increments on each transition into state PAT_LEN, including PAT_LEN -> PAT_LEN for self-overlapping patterns such as 1111.
  - It does not increment while holding with x_en=0.
  - It saturates at 2^CNT_W-1.
- Simultaneous clear and x_en: clear wins and the bit is dropped.
- Reset asserted mid-pattern: the partial match is discarded. Matching starts fresh from the next accepted bit.

Decomposition:
- Package moore_pkg holds:
  - state width function clog2_p1(PAT_LEN),
  - default pattern constants,
  - OVERLAP mode localparams (MODE_OVERLAP=1, MODE_RESTART=0).
- One sub-module, prefix_match (combinational):
  - inputs h_next, S_eff
  - output next state
  - parametrised by PAT_LEN and PATTERN.
- Top module holds the state, history and counter registers.

Test Plan:
- Default parameters, OVERLAP=1, stream 0,1,1,0,1,1,0 with x_en=1 -> y_out 1,2,3,4,2,3,4; detect high after bits 4 and 7; match_count=2.
- Same stream with OVERLAP=0 -> y_out 1,2,3,4,0,0,1; one detect; match_count=1.
- PATTERN=4'b1111, OVERLAP=1, six 1s -> y_out 1,2,3,4,4,4; detect held for 3 cycles; match_count=3.
- x_en low between bits (0,gap,1,gap,gap,1,0) -> state holds during gaps; detect after the final 0; count=1; count unchanged while detect holds.
- Async reset pulsed low between clock edges after bits 0,1,1 -> y_out=0 immediately. Then 1,1,0 -> no detect (state 0,0,1).
- CNT_W=2 with 5 overlapping matches -> match_count saturates at 3. clear at the same time as x_en=1 -> state=0 and count=0 next cycle; the bit is ignored.
